fetch_queue_ring: RTL and testbench
===================================

// Module: fetch_queue_ring
// PURPOSE
//  Parametrised circular instruction queue between icache fetch and decode. Accepts up to
//  IN_W instructions per cycle from fetch, presents the oldest OUT_W entries to decode, and
//  retires 0..OUT_W of them per cycle, as reported by decode. Head/tail pointers replace
//  shift-register movement. Flush empties the queue in one cycle.
// PARAMETERS
//  DEPTH  16  entries; power of two, >= 2*IN_W
//  IN_W   2   max instructions written per cycle (lanes of the fetch packet)
//  OUT_W  2   max instructions presented/retired per cycle
//  PRE_W  64  branch-prediction sideband bits per entry
//  EXC_W  16  exception-argument bits per fetch packet
// PORTS
//  clk         in   1            clock
//  rst         in   1            synchronous reset, active-high
//  flush       in   1            discard all entries (redirect)
//  stall       in   1            backend stall: no retire this cycle
//  in_valid    in   1            fetch packet valid
//  in_cnt      in   clog2(IN_W+1) lanes valid in packet (1..IN_W), lane 0 oldest
//  in_ir       in   32*IN_W      instruction words, lane i at [32i+:32]
//  in_pc       in   32           PC of lane 0; lane i PC = in_pc+4*i
//  in_npc      in   32           predicted next PC, copied to every lane
//  in_pre      in   PRE_W        prediction sideband, copied to every lane
//  in_excp     in   EXC_W        exception argument, lane 0 only; other lanes get 0
//  in_plv      in   2            privilege level, copied to every lane
//  in_ready    out  1            queue accepts a full IN_W packet this cycle
//  out_valid   out  OUT_W        slot j holds a valid entry (thermometer, slot 0 oldest)
//  out_ir/pc/npc/pre/excp/plv  out  OUT_W x field  entry fields, slot j = head+j
//  out_take    in   clog2(OUT_W+1) entries decode retires this cycle
//  count       out  clog2(DEPTH+1) occupied entries
// BEHAVIOUR
//  - Reset or flush: head=tail=count=0; out_valid=0; in_ready=1 next cycle. Flush overrides
//    in_valid and out_take in the same cycle; data RAM contents need not be cleared.
//  - in_ready = (DEPTH-count >= IN_W); combinational from registered count only.
//  - Push fires when in_valid & in_ready: lanes 0..in_cnt-1 written at tail..tail+in_cnt-1
//    (mod DEPTH); tail += in_cnt. in_cnt=0 or > IN_W with in_valid is illegal (assertion).
//  - Retire: eff_take = stall ? 0 : min(out_take, count); head += eff_take. Taking more than
//    valid slots is clipped, not an error. Data visible at outputs = current head (no bypass):
//    a pushed entry appears on out_* the cycle after the push (latency 1).
//  - Simultaneous push and retire allowed: count_next = count + pushed - eff_take.
//    Push eligibility uses pre-retire count (no same-cycle free-slot reuse).
//  - out_valid[j] = (count > j). Invalid slots drive data 0.
//  - Pointers are clog2(DEPTH) bits and wrap naturally; count disambiguates full/empty.
//  - Full: count=DEPTH-IN_W+1..DEPTH deasserts in_ready; packet held by fetch unchanged.
//  - Empty: out_valid=0; out_take ignored.
// STRUCTURE
//  - Shared package: fq_entry_t {ir, pc, npc, pre, excp, plv}; FQ_EXC_W, FQ_PRE_W constants.
//  - One sub-module fq_ring_ram: DEPTH x entry storage, IN_W write ports (consecutive
//    addresses), OUT_W asynchronous read ports; pointer/count logic stays in top.
// TESTING
//  1 rst then push in_cnt=2, pc=0x1C000000 -> next cycle out_valid=2'b11, out_pc0=0x1C000000,
//    out_pc1=0x1C000004, out_excp1=0, count=2.
//  2 push 8 packets of 2, no take -> count=16 after 8, in_ready=0 from count=15 onward;
//    9th packet held, count stays 16.
//  3 count=16, out_take=2 + in_valid -> count=14 (no push that cycle); next cycle push, count=16.
//  4 head near wrap (head=15, count=3) -> out_pc of slots read indices 15,0; take=2 -> head=1.
//  5 count=1, out_take=2 -> head+=1, count=0, out_valid=0; stall=1 with take=2 -> no change.
//  6 flush with in_valid & out_take=2 at count=9 -> count=0, out_valid=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/fetch_queue_ring_pkg.sv
// Shared types for the fetch queue: one stored instruction entry and the
// sideband widths it carries.
package fetch_queue_ring_pkg;

    localparam int FQ_PRE_W = 64;   // branch-prediction sideband bits per entry
    localparam int FQ_EXC_W = 16;   // exception-argument bits per entry

    // One queued instruction with everything decode needs alongside it.
    typedef struct packed {
        logic [31:0]         ir;
        logic [31:0]         pc;
        logic [31:0]         npc;
        logic [FQ_PRE_W-1:0] pre;
        logic [FQ_EXC_W-1:0] excp;
        logic [1:0]          plv;
    } fq_entry_t;

    // Build the entry for one lane of a fetch packet: the lane PC is offset
    // from lane 0, and only lane 0 carries the exception argument.
    function automatic fq_entry_t fq_lane_entry(
        input logic [31:0]         ir,
        input logic [31:0]         pc0,
        input logic [31:0]         npc,
        input logic [FQ_PRE_W-1:0] pre,
        input logic [FQ_EXC_W-1:0] excp,
        input logic [1:0]          plv,
        input int                  lane
    );
        fq_entry_t e;
        e.ir   = ir;
        e.pc   = pc0 + 32'(4 * lane);
        e.npc  = npc;
        e.pre  = pre;
        e.excp = (lane == 0) ? excp : '0;
        e.plv  = plv;
        return e;
    endfunction

endpackage

// File: rtl/fq_ring_ram.sv
// Circular entry storage for the fetch queue: IN_W write lanes landing on
// consecutive addresses from a base pointer, OUT_W asynchronous read ports
// returning consecutive addresses from the head pointer. Addresses wrap.
module fq_ring_ram
    import fetch_queue_ring_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int IN_W  = 2,
    parameter  int OUT_W = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int INC_W = $clog2(IN_W + 1)
) (
    input  logic                   clk,
    input  logic                   wr_en_i,
    input  logic [PTR_W-1:0]       wr_ptr_i,
    input  logic [INC_W-1:0]       wr_cnt_i,
    input  fq_entry_t [IN_W-1:0]   wr_data_i,
    input  logic [PTR_W-1:0]       rd_ptr_i,
    output fq_entry_t [OUT_W-1:0]  rd_data_o
);

    fq_entry_t mem_q [DEPTH];

    // Write the first wr_cnt_i lanes of the packet starting at wr_ptr_i.
    // NOTE: storage has no reset; the top's count gates stale entries off the
    // outputs, so clearing the array would only cost flops and reset fan-out.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int i = 0; i < IN_W; i++) begin
                if (i < int'(wr_cnt_i)) begin
                    // NOTE: clocked state uses <= so every lane sees the same
                    // pre-edge pointer and the write order cannot race.
                    mem_q[wr_ptr_i + PTR_W'(i)] <= wr_data_i[i];
                end
            end
        end
    end

    // Asynchronous reads of the OUT_W oldest slots; the pointer sum wraps.
    always_comb begin
        for (int j = 0; j < OUT_W; j++) begin
            rd_data_o[j] = mem_q[rd_ptr_i + PTR_W'(j)];
        end
    end

endmodule

// File: rtl/fetch_queue_ring.sv
// Circular instruction queue between icache fetch and decode. Head/tail
// pointers plus an occupancy count; decode sees the oldest OUT_W entries and
// retires up to OUT_W per cycle. Flush empties the queue in one cycle.
module fetch_queue_ring
    import fetch_queue_ring_pkg::*;
#(
    parameter  int DEPTH  = 16,
    parameter  int IN_W   = 2,
    parameter  int OUT_W  = 2,
    parameter  int PRE_W  = FQ_PRE_W,
    parameter  int EXC_W  = FQ_EXC_W,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int INC_W  = $clog2(IN_W + 1),
    localparam int TAKE_W = $clog2(OUT_W + 1),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         stall,
    input  logic                         in_valid,
    input  logic [INC_W-1:0]             in_cnt,
    input  logic [32*IN_W-1:0]           in_ir,
    input  logic [31:0]                  in_pc,
    input  logic [31:0]                  in_npc,
    input  logic [PRE_W-1:0]             in_pre,
    input  logic [EXC_W-1:0]             in_excp,
    input  logic [1:0]                   in_plv,
    output logic                         in_ready,
    output logic [OUT_W-1:0]             out_valid,
    output logic [OUT_W-1:0][31:0]       out_ir,
    output logic [OUT_W-1:0][31:0]       out_pc,
    output logic [OUT_W-1:0][31:0]       out_npc,
    output logic [OUT_W-1:0][PRE_W-1:0]  out_pre,
    output logic [OUT_W-1:0][EXC_W-1:0]  out_excp,
    output logic [OUT_W-1:0][1:0]        out_plv,
    input  logic [TAKE_W-1:0]            out_take,
    output logic [CNT_W-1:0]             count
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             push;
    logic [CNT_W-1:0] push_cnt;
    logic [CNT_W-1:0] take_req;
    logic [CNT_W-1:0] eff_take;

    fq_entry_t [IN_W-1:0]  wr_data;
    fq_entry_t [OUT_W-1:0] rd_data;

    // Room for a whole packet, judged on the registered count only so the
    // ready path never depends on this cycle's retire.
    assign in_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(IN_W);
    assign push     = in_valid & in_ready & ~flush;
    assign push_cnt = push ? CNT_W'(in_cnt) : '0;
    assign take_req = stall ? '0 : CNT_W'(out_take);
    assign eff_take = (take_req > count_q) ? count_q : take_req;
    assign count    = count_q;

    // Pointer and occupancy next state; flush wins over push and retire.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(eff_take);
            tail_d  = tail_q + PTR_W'(push_cnt);
            count_d = count_q + push_cnt - eff_take;
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Expand the fetch packet into per-lane entries.
    always_comb begin
        wr_data = '0;
        for (int i = 0; i < IN_W; i++) begin
            wr_data[i] = fq_lane_entry(in_ir[32*i +: 32], in_pc, in_npc,
                                       in_pre, in_excp, in_plv, i);
        end
    end

    fq_ring_ram #(
        .DEPTH (DEPTH),
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (push),
        .wr_ptr_i  (tail_q),
        .wr_cnt_i  (in_cnt),
        .wr_data_i (wr_data),
        .rd_ptr_i  (head_q),
        .rd_data_o (rd_data)
    );

    // Present the oldest slots; slots beyond the occupancy drive zeros.
    always_comb begin
        out_valid = '0;
        out_ir    = '0;
        out_pc    = '0;
        out_npc   = '0;
        out_pre   = '0;
        out_excp  = '0;
        out_plv   = '0;
        for (int j = 0; j < OUT_W; j++) begin
            out_valid[j] = count_q > CNT_W'(j);
            if (out_valid[j]) begin
                out_ir[j]   = rd_data[j].ir;
                out_pc[j]   = rd_data[j].pc;
                out_npc[j]  = rd_data[j].npc;
                out_pre[j]  = rd_data[j].pre;
                out_excp[j] = rd_data[j].excp;
                out_plv[j]  = rd_data[j].plv;
            end
        end
    end

    // A valid fetch packet must carry between 1 and IN_W lanes.
    assert property (@(posedge clk) disable iff (rst)
        in_valid |-> (in_cnt != '0 && int'(in_cnt) <= IN_W));

endmodule

// File: tb/tb_fetch_queue_ring.sv
// Self-checking bench for fetch_queue_ring: directed scenarios followed by
// random traffic, all compared against a queue-based model of the contents.
module tb_fetch_queue_ring;
    import fetch_queue_ring_pkg::*;

    localparam int DEPTH = 16;
    localparam int IN_W  = 2;
    localparam int OUT_W = 2;

    logic                          clk;
    logic                          rst;
    logic                          flush;
    logic                          stall;
    logic                          in_valid;
    logic [1:0]                    in_cnt;
    logic [63:0]                   in_ir;
    logic [31:0]                   in_pc;
    logic [31:0]                   in_npc;
    logic [FQ_PRE_W-1:0]           in_pre;
    logic [FQ_EXC_W-1:0]           in_excp;
    logic [1:0]                    in_plv;
    logic                          in_ready;
    logic [OUT_W-1:0]              out_valid;
    logic [OUT_W-1:0][31:0]        out_ir;
    logic [OUT_W-1:0][31:0]        out_pc;
    logic [OUT_W-1:0][31:0]        out_npc;
    logic [OUT_W-1:0][FQ_PRE_W-1:0] out_pre;
    logic [OUT_W-1:0][FQ_EXC_W-1:0] out_excp;
    logic [OUT_W-1:0][1:0]         out_plv;
    logic [1:0]                    out_take;
    logic [4:0]                    count;

    fetch_queue_ring #(
        .DEPTH (DEPTH),
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .stall     (stall),
        .in_valid  (in_valid),
        .in_cnt    (in_cnt),
        .in_ir     (in_ir),
        .in_pc     (in_pc),
        .in_npc    (in_npc),
        .in_pre    (in_pre),
        .in_excp   (in_excp),
        .in_plv    (in_plv),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ir    (out_ir),
        .out_pc    (out_pc),
        .out_npc   (out_npc),
        .out_pre   (out_pre),
        .out_excp  (out_excp),
        .out_plv   (out_plv),
        .out_take  (out_take),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Reference model: queue of entries in age order plus the number of
    // entries ever retired/pushed modulo DEPTH (where head/tail should sit).
    fq_entry_t model_q[$];
    int        head_m;
    int        tail_m;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every visible output (and the pointers) with the model.
    task automatic check_all(input string tag);
        int sz;
        sz = model_q.size();
        chk({tag, ".count"}, 64'(count), 64'(sz));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'((DEPTH - sz) >= IN_W));
        chk({tag, ".head"}, 64'(dut.head_q), 64'(head_m));
        chk({tag, ".tail"}, 64'(dut.tail_q), 64'(tail_m));
        for (int j = 0; j < OUT_W; j++) begin
            fq_entry_t e;
            e = (j < sz) ? model_q[j] : '0;
            chk($sformatf("%s.valid%0d", tag, j), 64'(out_valid[j]), 64'(j < sz));
            chk($sformatf("%s.ir%0d", tag, j),   64'(out_ir[j]),   64'(e.ir));
            chk($sformatf("%s.pc%0d", tag, j),   64'(out_pc[j]),   64'(e.pc));
            chk($sformatf("%s.npc%0d", tag, j),  64'(out_npc[j]),  64'(e.npc));
            chk($sformatf("%s.pre%0d", tag, j),  out_pre[j],       e.pre);
            chk($sformatf("%s.excp%0d", tag, j), 64'(out_excp[j]), 64'(e.excp));
            chk($sformatf("%s.plv%0d", tag, j),  64'(out_plv[j]),  64'(e.plv));
        end
    endtask

    // One clock: drive inputs at the falling edge, let the rising edge act,
    // apply the same rules to the model, then check at the next falling edge.
    task automatic cycle(input string tag, input logic v, input int cnt, input int take,
                         input logic st, input logic fl, input logic [31:0] pc);
        int sz;
        int tk;
        in_valid = v;
        in_cnt   = 2'(cnt);
        out_take = 2'(take);
        stall    = st;
        flush    = fl;
        in_pc    = pc;
        in_ir    = {$urandom, $urandom};
        in_npc   = $urandom;
        in_pre   = {$urandom, $urandom};
        in_excp  = 16'($urandom);
        in_plv   = 2'($urandom);
        @(posedge clk);
        sz = model_q.size();
        if (fl) begin
            model_q.delete();
            head_m = 0;
            tail_m = 0;
        end else begin
            tk = st ? 0 : take;
            if (tk > sz) tk = sz;
            for (int k = 0; k < tk; k++) void'(model_q.pop_front());
            head_m = (head_m + tk) % DEPTH;
            if (v && (DEPTH - sz) >= IN_W) begin
                for (int l = 0; l < cnt; l++) begin
                    fq_entry_t e;
                    e.ir   = in_ir[32*l +: 32];
                    e.pc   = in_pc + 32'(4 * l);
                    e.npc  = in_npc;
                    e.pre  = in_pre;
                    e.excp = (l == 0) ? in_excp : 16'h0;
                    e.plv  = in_plv;
                    model_q.push_back(e);
                end
                tail_m = (tail_m + cnt) % DEPTH;
            end
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        stall    = 1'b0;
        in_valid = 1'b0;
        in_cnt   = 2'd1;
        in_ir    = '0;
        in_pc    = '0;
        in_npc   = '0;
        in_pre   = '0;
        in_excp  = '0;
        in_plv   = '0;
        out_take = '0;
        head_m   = 0;
        tail_m   = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all("reset");
        chk("reset.in_ready", 64'(in_ready), 64'd1);

        // 1: single packet, visible one cycle later with per-lane PC/excp.
        cycle("t1", 1'b1, 2, 0, 1'b0, 1'b0, 32'h1C000000);
        chk("t1.out_valid", 64'(out_valid), 64'h3);
        chk("t1.pc0", 64'(out_pc[0]), 64'h1C000000);
        chk("t1.pc1", 64'(out_pc[1]), 64'h1C000004);
        chk("t1.excp1", 64'(out_excp[1]), 64'h0);
        chk("t1.count", 64'(count), 64'd2);

        // 2: fill to DEPTH; the ninth packet is held.
        for (int p = 1; p < 8; p++)
            cycle($sformatf("t2.p%0d", p), 1'b1, 2, 0, 1'b0, 1'b0, $urandom);
        chk("t2.full_count", 64'(count), 64'd16);
        chk("t2.full_ready", 64'(in_ready), 64'd0);
        cycle("t2.held", 1'b1, 2, 0, 1'b0, 1'b0, $urandom);
        chk("t2.held_count", 64'(count), 64'd16);

        // 3: retire two while full: no push that cycle, push the next.
        cycle("t3.take", 1'b1, 2, 2, 1'b0, 1'b0, $urandom);
        chk("t3.take_count", 64'(count), 64'd14);
        cycle("t3.push", 1'b1, 2, 0, 1'b0, 1'b0, $urandom);
        chk("t3.push_count", 64'(count), 64'd16);

        // 4: walk head to 15 with three entries, then retire across the wrap.
        cycle("t4.flush", 1'b0, 1, 0, 1'b0, 1'b1, $urandom);
        for (int p = 0; p < 8; p++)
            cycle($sformatf("t4.fill%0d", p), 1'b1, 2, 0, 1'b0, 1'b0, $urandom);
        for (int p = 0; p < 7; p++)
            cycle($sformatf("t4.drain%0d", p), 1'b0, 1, 2, 1'b0, 1'b0, $urandom);
        cycle("t4.take1", 1'b0, 1, 1, 1'b0, 1'b0, $urandom);
        cycle("t4.wrap", 1'b1, 2, 0, 1'b0, 1'b0, 32'h00400000);
        chk("t4.head15", 64'(dut.head_q), 64'd15);
        chk("t4.count3", 64'(count), 64'd3);
        cycle("t4.take2", 1'b0, 1, 2, 1'b0, 1'b0, $urandom);
        chk("t4.head1", 64'(dut.head_q), 64'd1);
        chk("t4.pc0_after", 64'(out_pc[0]), 64'h00400004);

        // 5: over-take is clipped; stall blocks retire.
        cycle("t5.clip", 1'b0, 1, 2, 1'b0, 1'b0, $urandom);
        chk("t5.empty_valid", 64'(out_valid), 64'h0);
        cycle("t5.empty_take", 1'b0, 1, 2, 1'b0, 1'b0, $urandom);
        cycle("t5.push1", 1'b1, 1, 0, 1'b0, 1'b0, $urandom);
        cycle("t5.stall", 1'b0, 1, 2, 1'b1, 1'b0, $urandom);
        chk("t5.stall_count", 64'(count), 64'd1);

        // 6: flush wins over push and retire.
        for (int p = 0; p < 4; p++)
            cycle($sformatf("t6.fill%0d", p), 1'b1, 2, 0, 1'b0, 1'b0, $urandom);
        chk("t6.count9", 64'(count), 64'd9);
        cycle("t6.flush", 1'b1, 2, 2, 1'b0, 1'b1, $urandom);
        chk("t6.flush_count", 64'(count), 64'd0);
        chk("t6.flush_valid", 64'(out_valid), 64'h0);
        chk("t6.flush_ready", 64'(in_ready), 64'd1);

        // Random traffic: mixed packet sizes, over-takes, stalls, rare flushes.
        for (int n = 0; n < 600; n++) begin
            cycle($sformatf("rnd%0d", n),
                  ($urandom_range(0, 3) != 0),
                  $urandom_range(1, 2),
                  $urandom_range(0, 3),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 40) == 0),
                  $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
